// File: rtl/slow_peripheral_bridge_arbiter_pkg.sv
// Shared types for the slow peripheral bridge arbiter.
// Requester ids and the arbiter state encoding.
package slow_peripheral_bridge_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_CPU = 1'b0;
  localparam req_id_t REQ_DMA = 1'b1;

endpackage

// File: rtl/slow_peripheral_bridge_arbiter_tagq.sv
// In-order read-tag FIFO: remembers which requester owns
// each outstanding bridge read.
module slow_peripheral_bridge_arbiter_tagq
  import slow_peripheral_bridge_arbiter_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  req_id_t          push_id,
  input  logic             pop,
  output req_id_t          head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  req_id_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic             do_push;
  logic             do_pop;

  assign full    = count == CNT_FULL;
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_id;
  end

endmodule

// File: rtl/slow_peripheral_bridge_arbiter.sv
// Round-robin two-master arbiter for the slow bridge slave port,
// routing pipelined read responses back by tag.
module slow_peripheral_bridge_arbiter
  import slow_peripheral_bridge_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8,
  parameter int PEND_W      = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  output logic                m0_endofpacket,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic                m1_endofpacket,
  output logic [ADDR_W-1:0]   b_address,
  output logic [ADDR_W-1:0]   b_nativeaddress,
  output logic [DATA_W/8-1:0] b_byteenable,
  output logic                b_read,
  output logic                b_write,
  output logic [DATA_W-1:0]   b_writedata,
  input  logic                b_waitrequest,
  input  logic [DATA_W-1:0]   b_readdata,
  input  logic                b_readdatavalid,
  input  logic                b_endofpacket,
  output logic                rsp_error
);

  arb_state_e        state_q;
  req_id_t           grant_q;
  req_id_t           rr_ptr_q;
  logic              rsp_error_q;
  logic              busy;
  logic              sel1;
  logic              g_read;
  logic              g_write;
  logic              g_cmd;
  logic              accept;
  logic              elig0;
  logic              elig1;
  logic              rsp_ok;
  logic              tq_full;
  logic              tq_empty;
  req_id_t           tq_head;
  logic [PEND_W-1:0] pending;

  assign busy    = state_q == ST_BUSY;
  assign sel1    = grant_q == REQ_DMA;
  assign g_read  = sel1 ? m1_read  : m0_read;
  assign g_write = sel1 ? m1_write : m0_write;
  assign g_cmd   = g_read | g_write;
  assign accept  = busy & g_cmd & ~b_waitrequest;

  assign b_read          = busy & g_read;
  assign b_write         = busy & g_write;
  assign b_address       = sel1 ? m1_address    : m0_address;
  assign b_nativeaddress = b_address;
  assign b_byteenable    = sel1 ? m1_byteenable : m0_byteenable;
  assign b_writedata     = sel1 ? m1_writedata  : m0_writedata;

  assign m0_waitrequest = ~(busy & ~sel1 & ~b_waitrequest);
  assign m1_waitrequest = ~(busy &  sel1 & ~b_waitrequest);

  // A read may only be granted if its tag is guaranteed a slot.
  assign elig0 = m0_write | (m0_read & ~tq_full);
  assign elig1 = m1_write | (m1_read & ~tq_full);

  assign rsp_ok           = b_readdatavalid & ~tq_empty;
  assign m0_readdatavalid = rsp_ok & (tq_head == REQ_CPU);
  assign m1_readdatavalid = rsp_ok & (tq_head == REQ_DMA);
  assign m0_readdata      = b_readdata;
  assign m1_readdata      = b_readdata;
  assign m0_endofpacket   = b_endofpacket;
  assign m1_endofpacket   = b_endofpacket;
  assign rsp_error        = rsp_error_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= REQ_CPU;
      rr_ptr_q <= REQ_CPU;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (elig0 | elig1) begin
            state_q <= ST_BUSY;
            grant_q <= (elig0 & elig1) ? rr_ptr_q :
                       (elig1 ? REQ_DMA : REQ_CPU);
          end
        end
        ST_BUSY: begin
          if (!g_cmd) begin
            state_q <= ST_IDLE;
          end else if (!b_waitrequest) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= ~grant_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rsp_error_q <= 1'b0;
    else if (b_readdatavalid & tq_empty)
      rsp_error_q <= 1'b1;
  end

  slow_peripheral_bridge_arbiter_tagq #(
    .DEPTH (MAX_PENDING),
    .CNT_W (PEND_W)
  ) u_tagq (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept & g_read),
    .push_id (grant_q),
    .pop     (b_readdatavalid),
    .head    (tq_head),
    .count   (pending),
    .full    (tq_full),
    .empty   (tq_empty)
  );

endmodule

// File: tb/tb_slow_peripheral_bridge_arbiter.sv
// Bench for slow_peripheral_bridge_arbiter: directed scenarios
// plus random traffic against a queue-based reference model.
module tb_slow_peripheral_bridge_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MP = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [1:0] mrd = '0;
  logic [1:0] mwr = '0;
  logic [1:0][AW-1:0] maddr = '0;
  logic [1:0][3:0] mbe = '0;
  logic [1:0][DW-1:0] mwd = '0;
  logic [1:0] mwait;
  logic [1:0] mrdv;
  logic [1:0] meop;
  logic [1:0][DW-1:0] mrdata;

  logic [AW-1:0] b_address;
  logic [AW-1:0] b_nativeaddress;
  logic [3:0] b_byteenable;
  logic b_read;
  logic b_write;
  logic [DW-1:0] b_writedata;
  logic bwait = 1'b0;
  logic brdv = 1'b0;
  logic beop = 1'b0;
  logic [DW-1:0] brdata = '0;
  logic rsp_error;

  int checks = 0;
  int failures = 0;

  int m_owner = -1;
  int m_rr = 0;
  int mq[$];
  bit m_err = 1'b0;
  bit mb;
  bit mc;
  int mg;
  int msz;
  logic [1:0] mew;
  logic [1:0] mer;
  logic [1:0] mel;

  int exp_id [4] = '{0, 1, 1, 0};

  slow_peripheral_bridge_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (maddr[0]),
    .m0_byteenable    (mbe[0]),
    .m0_read          (mrd[0]),
    .m0_write         (mwr[0]),
    .m0_writedata     (mwd[0]),
    .m0_waitrequest   (mwait[0]),
    .m0_readdata      (mrdata[0]),
    .m0_readdatavalid (mrdv[0]),
    .m0_endofpacket   (meop[0]),
    .m1_address       (maddr[1]),
    .m1_byteenable    (mbe[1]),
    .m1_read          (mrd[1]),
    .m1_write         (mwr[1]),
    .m1_writedata     (mwd[1]),
    .m1_waitrequest   (mwait[1]),
    .m1_readdata      (mrdata[1]),
    .m1_readdatavalid (mrdv[1]),
    .m1_endofpacket   (meop[1]),
    .b_address        (b_address),
    .b_nativeaddress  (b_nativeaddress),
    .b_byteenable     (b_byteenable),
    .b_read           (b_read),
    .b_write          (b_write),
    .b_writedata      (b_writedata),
    .b_waitrequest    (bwait),
    .b_readdata       (brdata),
    .b_readdatavalid  (brdv),
    .b_endofpacket    (beop),
    .rsp_error        (rsp_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction owner at a time, tags in a queue.
  always @(negedge clk) begin
    if (!reset_n) begin
      m_owner = -1;
      m_rr = 0;
      mq.delete();
      m_err = 1'b0;
      chk("rst_wait", {30'd0, mwait}, 32'd3);
      chk("rst_bcmd", {30'd0, b_read, b_write}, 32'd0);
      chk("rst_rdv", {30'd0, mrdv}, 32'd0);
      chk("rst_err", {31'd0, rsp_error}, 32'd0);
      chk("rst_pend", {28'd0, dut.pending}, 32'd0);
    end else begin
      msz = mq.size();
      mb = m_owner >= 0;
      mg = mb ? m_owner : 0;
      mc = mb && (mrd[mg] || mwr[mg]);
      mew = 2'b11;
      if (mb && !bwait) mew[mg] = 1'b0;
      mer = 2'b00;
      if (brdv && msz > 0) mer[mq[0]] = 1'b1;
      chk("m_wait", {30'd0, mwait}, {30'd0, mew});
      chk("m_bread", {31'd0, b_read}, {31'd0, mb && mrd[mg]});
      chk("m_bwrite", {31'd0, b_write}, {31'd0, mb && mwr[mg]});
      if (mc) begin
        chk("m_baddr", {20'd0, b_address}, {20'd0, maddr[mg]});
        chk("m_bnaddr", {20'd0, b_nativeaddress}, {20'd0, maddr[mg]});
        chk("m_bbe", {28'd0, b_byteenable}, {28'd0, mbe[mg]});
        chk("m_bwd", b_writedata, mwd[mg]);
      end
      chk("m_rdv", {30'd0, mrdv}, {30'd0, mer});
      chk("m_rdata0", mrdata[0], brdata);
      chk("m_rdata1", mrdata[1], brdata);
      chk("m_eop", {30'd0, meop}, {30'd0, beop, beop});
      chk("m_err", {31'd0, rsp_error}, {31'd0, m_err});
      chk("m_pend", {28'd0, dut.pending}, msz);
      mel[0] = mwr[0] || (mrd[0] && msz < MP);
      mel[1] = mwr[1] || (mrd[1] && msz < MP);
      if (brdv) begin
        if (msz == 0) m_err = 1'b1;
        else void'(mq.pop_front());
      end
      if (mb) begin
        if (!mc) begin
          m_owner = -1;
        end else if (!bwait) begin
          if (mrd[mg]) mq.push_back(mg);
          m_rr = 1 - mg;
          m_owner = -1;
        end
      end else if (mel != 2'b00) begin
        m_owner = (mel == 2'b11) ? m_rr : (mel[1] ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input int id, input bit rd,
                        input logic [AW-1:0] a);
    bit got;
    got = 1'b0;
    mrd[id] = rd;
    mwr[id] = !rd;
    maddr[id] = a;
    mwd[id] = $urandom;
    mbe[id] = 4'hF;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = !mwait[id];
      tick();
    end
    mrd[id] = 1'b0;
    mwr[id] = 1'b0;
    chk("cmd_accept", {31'd0, got}, 32'd1);
  endtask

  task automatic rand_phase(input int ncyc, input int rd_pct,
                            input int wait_pct, input int rdv_pct,
                            input bit drop_en, input int st_pct);
    bit [1:0] act;
    bit [1:0] acc;
    act = mrd | mwr;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) acc[i] = act[i] && !mwait[i];
      tick();
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || (act[i] && drop_en &&
            $urandom_range(199) == 0)) begin
          act[i] = 1'b0;
          mrd[i] = 1'b0;
          mwr[i] = 1'b0;
        end
        if (!act[i] && $urandom_range(99) < st_pct) begin
          act[i] = 1'b1;
          if ($urandom_range(99) < rd_pct) mrd[i] = 1'b1;
          else mwr[i] = 1'b1;
          maddr[i] = AW'($urandom);
          mwd[i] = $urandom;
          mbe[i] = 4'($urandom);
        end
      end
      bwait = $urandom_range(99) < wait_pct;
      brdv = mq.size() > 0 && $urandom_range(99) < rdv_pct;
      brdata = $urandom;
      beop = 1'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got0;
    bit got1;
    int n;
    int last;
    int gid;

    repeat (2) @(negedge clk);
    chk("reset_wait0", {31'd0, mwait[0]}, 32'd1);
    tick();
    reset_n = 1'b1;

    // single write
    mwr[0] = 1'b1;
    maddr[0] = 12'h123;
    mwd[0] = 32'hDEADBEEF;
    mbe[0] = 4'hF;
    @(negedge clk);
    chk("sw_idle_bwrite", {31'd0, b_write}, 32'd0);
    chk("sw_idle_wait", {31'd0, mwait[0]}, 32'd1);
    tick();
    @(negedge clk);
    chk("sw_bwrite", {31'd0, b_write}, 32'd1);
    chk("sw_addr", {20'd0, b_address}, 32'h123);
    chk("sw_data", b_writedata, 32'hDEADBEEF);
    chk("sw_wait0", {31'd0, mwait[0]}, 32'd0);
    chk("sw_pend", {28'd0, dut.pending}, 32'd0);
    tick();
    mwr[0] = 1'b0;
    @(negedge clk);
    chk("sw_bwrite_once", {31'd0, b_write}, 32'd0);
    tick();

    // interleaved reads
    do_cmd(0, 1'b1, 12'h010);
    do_cmd(1, 1'b1, 12'h020);
    do_cmd(1, 1'b1, 12'h021);
    do_cmd(0, 1'b1, 12'h011);
    chk("il_pend4", {28'd0, dut.pending}, 32'd4);
    for (int k = 0; k < 4; k++) begin
      brdv = 1'b1;
      brdata = k + 1;
      @(negedge clk);
      chk("il_rdv0", {31'd0, mrdv[0]}, {31'd0, exp_id[k] == 0});
      chk("il_rdv1", {31'd0, mrdv[1]}, {31'd0, exp_id[k] == 1});
      chk("il_data", mrdata[exp_id[k]], k + 1);
      tick();
    end
    brdv = 1'b0;
    @(negedge clk);
    chk("il_pend0", {28'd0, dut.pending}, 32'd0);
    tick();

    // response with nothing pending
    brdv = 1'b1;
    brdata = 32'h77;
    @(negedge clk);
    chk("ep_rdv", {30'd0, mrdv}, 32'd0);
    tick();
    brdv = 1'b0;
    @(negedge clk);
    chk("ep_err", {31'd0, rsp_error}, 32'd1);
    chk("ep_pend", {28'd0, dut.pending}, 32'd0);
    tick();

    // reset while busy
    do_cmd(0, 1'b1, 12'h040);
    mrd[1] = 1'b1;
    maddr[1] = 12'h041;
    bwait = 1'b1;
    tick();
    @(negedge clk);
    chk("rb_bread", {31'd0, b_read}, 32'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rb_async_bread", {31'd0, b_read}, 32'd0);
    chk("rb_pend", {28'd0, dut.pending}, 32'd0);
    chk("rb_err", {31'd0, rsp_error}, 32'd0);
    mrd[1] = 1'b0;
    bwait = 1'b0;
    @(negedge clk);
    tick();
    reset_n = 1'b1;

    // round robin with both writing continuously
    mwr = 2'b11;
    maddr[0] = 12'h0A0;
    maddr[1] = 12'h0B0;
    n = 0;
    last = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      @(negedge clk);
      if (!mwait[0] || !mwait[1]) begin
        gid = mwait[0] ? 1 : 0;
        chk("rr_grant", gid, n % 2);
        if (n > 0) chk("rr_space", c - last, 32'd2);
        last = c;
        n++;
      end
      if (n < 8) tick();
    end
    chk("rr_count", n, 32'd8);
    tick();
    mwr = 2'b00;
    tick();

    // bridge stall on an m1 read with m0 waiting
    mrd[1] = 1'b1;
    maddr[1] = 12'h0C1;
    bwait = 1'b1;
    @(negedge clk);
    tick();
    mwr[0] = 1'b1;
    maddr[0] = 12'h0C0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("st_bread", {31'd0, b_read}, 32'd1);
      chk("st_addr", {20'd0, b_address}, 32'h0C1);
      chk("st_wait", {30'd0, mwait}, 32'd3);
      tick();
    end
    bwait = 1'b0;
    @(negedge clk);
    chk("st_accept", {30'd0, mwait}, 32'd1);
    tick();
    mrd[1] = 1'b0;
    @(negedge clk);
    chk("st_idle", {31'd0, b_write}, 32'd0);
    tick();
    @(negedge clk);
    chk("st_m0_next", {30'd0, mwait}, 32'd2);
    chk("st_m0_bwrite", {31'd0, b_write}, 32'd1);
    tick();
    mwr[0] = 1'b0;
    brdv = 1'b1;
    @(negedge clk);
    chk("st_rsp_m1", {30'd0, mrdv}, 32'd2);
    tick();
    brdv = 1'b0;

    // full tag queue
    for (int k = 0; k < MP; k++) do_cmd(0, 1'b1, AW'(12'h100 + k));
    chk("fq_pend8", {28'd0, dut.pending}, 32'd8);
    mrd[0] = 1'b1;
    maddr[0] = 12'h1FF;
    mwr[1] = 1'b1;
    maddr[1] = 12'h2FF;
    got0 = 1'b0;
    got1 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (!mwait[0]) got0 = 1'b1;
      if (!mwait[1]) got1 = 1'b1;
      tick();
      if (got1) mwr[1] = 1'b0;
    end
    chk("fq_m1_write", {31'd0, got1}, 32'd1);
    chk("fq_m0_stall", {31'd0, got0}, 32'd0);
    chk("fq_pend_hold", {28'd0, dut.pending}, 32'd8);
    brdv = 1'b1;
    brdata = 32'h55;
    @(negedge clk);
    chk("fq_pop_m0", {30'd0, mrdv}, 32'd1);
    tick();
    brdv = 1'b0;
    got0 = 1'b0;
    for (int c = 0; c < 6 && !got0; c++) begin
      @(negedge clk);
      got0 = !mwait[0];
      tick();
    end
    mrd[0] = 1'b0;
    chk("fq_refill", {31'd0, got0}, 32'd1);
    @(negedge clk);
    chk("fq_pend_refull", {28'd0, dut.pending}, 32'd8);
    tick();
    brdv = 1'b1;
    for (int k = 0; k < MP; k++) begin
      @(negedge clk);
      chk("fq_drain", {30'd0, mrdv}, 32'd1);
      tick();
    end
    brdv = 1'b0;
    @(negedge clk);
    chk("fq_pend0", {28'd0, dut.pending}, 32'd0);
    tick();

    // random traffic
    rand_phase(600, 50, 30, 30, 1'b1, 40);
    rand_phase(600, 90, 10, 3, 1'b0, 60);
    rand_phase(600, 70, 50, 60, 1'b1, 50);
    rand_phase(600, 80, 0, 10, 1'b0, 100);
    rand_phase(80, 50, 0, 100, 1'b0, 0);
    mrd = '0;
    mwr = '0;
    brdv = 1'b0;
    @(negedge clk);
    chk("end_pend0", {28'd0, dut.pending}, 32'd0);
    chk("end_err", {31'd0, rsp_error}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
